// File: rtl/pbkdf2_pkg.sv
// Shared types, constants and the SHA-256 final-block padding helper for the PBKDF2 HMAC-SHA256 engine.
// Pure declarations: no latency, no flow control.
package pbkdf2_pkg;

   localparam int BLOCK_W  = 512;
   localparam int DIGEST_W = 256;

   localparam logic [BLOCK_W-1:0] IPAD = {64{8'h36}};
   localparam logic [BLOCK_W-1:0] OPAD = {64{8'h5c}};

   localparam logic [DIGEST_W-1:0] SHA_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] SHA_K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   typedef enum logic [3:0] {
      S_IDLE, S_IK, S_W1, S_IM, S_W2, S_OK, S_W3, S_OM, S_W4, S_ACC, S_DONE
   } state_t;

   // data holds len_bytes of payload right-aligned; the length field counts the preceding 64-byte key block.
   function automatic logic [BLOCK_W-1:0] sha_pad(input logic [BLOCK_W-1:0] data, input int len_bytes);
      logic [BLOCK_W-1:0] blk;
      blk = data << (BLOCK_W - 8 * len_bytes);
      blk = blk | (BLOCK_W'(8'h80) << (BLOCK_W - 8 - 8 * len_bytes));
      blk[63:0] = 64'((64 + len_bytes) * 8);
      return blk;
   endfunction

endpackage

// File: rtl/pbkdf2_hmac_sha256_core.sv
// Iterative SHA-256 compression core, one round per clock; digest valid 65 cycles after a block is accepted.
// Accepts a block only when idle; holds the digest until out_rdy, chaining state survives for new_hash=0.
module pbkdf2_hmac_sha256_core
   import pbkdf2_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_in_vld,
   output logic                o_in_rdy,
   input  logic [BLOCK_W-1:0]  i_in_dat,
   input  logic                i_new_hash,
   output logic                o_out_vld,
   input  logic                i_out_rdy,
   output logic [DIGEST_W-1:0] o_out_dat
);

   logic [31:0] r_w [16];
   logic [31:0] r_v [8];
   logic [31:0] r_h [8];
   logic [5:0]  r_rnd;
   logic        r_busy;
   logic        r_done;

   logic [31:0] w_t1;
   logic [31:0] w_t2;
   logic [31:0] w_w_nxt;
   logic [31:0] w_v_nxt [8];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   assign w_t1 = r_v[7] + (rotr(r_v[4], 6) ^ rotr(r_v[4], 11) ^ rotr(r_v[4], 25))
               + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + SHA_K[r_rnd] + r_w[0];
   assign w_t2 = (rotr(r_v[0], 2) ^ rotr(r_v[0], 13) ^ rotr(r_v[0], 22))
               + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
   // r_w is a sliding 16-word window: r_w[0] is W[t], the new word is W[t+16].
   assign w_w_nxt = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10)) + r_w[9]
                  + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3)) + r_w[0];

   assign w_v_nxt[0] = w_t1 + w_t2;
   assign w_v_nxt[1] = r_v[0];
   assign w_v_nxt[2] = r_v[1];
   assign w_v_nxt[3] = r_v[2];
   assign w_v_nxt[4] = r_v[3] + w_t1;
   assign w_v_nxt[5] = r_v[4];
   assign w_v_nxt[6] = r_v[5];
   assign w_v_nxt[7] = r_v[6];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_rnd  <= '0;
         for (int i = 0; i < 16; i++) r_w[i] <= '0;
         for (int i = 0; i < 8; i++) begin
            r_v[i] <= '0;
            r_h[i] <= '0;
         end
      end else if (r_busy) begin
         r_v <= w_v_nxt;
         for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
         r_w[15] <= w_w_nxt;
         r_rnd   <= r_rnd + 6'd1;
         if (r_rnd == 6'd63) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + w_v_nxt[i];
         end
      end else if (r_done) begin
         if (i_out_rdy) r_done <= 1'b0;
      end else if (i_in_vld) begin
         for (int i = 0; i < 16; i++) r_w[i] <= i_in_dat[BLOCK_W-1-32*i -: 32];
         for (int i = 0; i < 8; i++) begin
            r_v[i] <= i_new_hash ? SHA_IV[DIGEST_W-1-32*i -: 32] : r_h[i];
            if (i_new_hash) r_h[i] <= SHA_IV[DIGEST_W-1-32*i -: 32];
         end
         r_busy <= 1'b1;
         r_rnd  <= '0;
      end
   end

   assign o_in_rdy  = !r_busy && !r_done;
   assign o_out_vld = r_done;
   assign o_out_dat = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6], r_h[7]};

endmodule

// File: rtl/pbkdf2_hmac_sha256.sv
// PBKDF2 block engine: T = U_1^..^U_c with U_j = HMAC-SHA256(K, U_{j-1}); ~4x67+1 cycles per iteration, one request in flight.
// Holds dk_o/v_o until r_i; PBKDF2_ITER_TRACE_EN adds the u_o/u_v_o per-iteration trace (no backpressure).
module pbkdf2_hmac_sha256
   import pbkdf2_pkg::*;
#(
   parameter int KEY_BYTES = 32,
   parameter int MSG_BYTES = 8,
   parameter int ITER_W    = 32
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [KEY_BYTES*8-1:0] key_i,
   input  logic [MSG_BYTES*8-1:0] msg_i,
   input  logic [ITER_W-1:0]      iter_i,
   input  logic                   v_i,
   output logic                   r_o,
   output logic [DIGEST_W-1:0]    dk_o,
   output logic                   v_o,
   input  logic                   r_i,
   output logic                   busy_o
`ifdef PBKDF2_ITER_TRACE_EN
   ,
   output logic [DIGEST_W-1:0]    u_o,
   output logic                   u_v_o
`endif
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [BLOCK_W-1:0]     r_k0;
   logic [MSG_BYTES*8-1:0] r_msg;
   logic [ITER_W-1:0]      r_iter;
   logic [ITER_W-1:0]      r_cnt;
   logic [DIGEST_W-1:0]    r_acc;
   logic [DIGEST_W-1:0]    r_uprev;
   logic [DIGEST_W-1:0]    r_idig;
   logic [DIGEST_W-1:0]    r_dk;

   logic                   w_core_in_vld;
   logic                   w_core_in_rdy;
   logic [BLOCK_W-1:0]     w_core_blk;
   logic                   w_core_new;
   logic                   w_core_out_vld;
   logic                   w_core_out_rdy;
   logic [DIGEST_W-1:0]    w_core_dig;
   logic                   w_xfer;
   logic                   w_dig_take;
   logic                   w_last;

   pbkdf2_hmac_sha256_core u_core (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_in_vld   (w_core_in_vld),
      .o_in_rdy   (w_core_in_rdy),
      .i_in_dat   (w_core_blk),
      .i_new_hash (w_core_new),
      .o_out_vld  (w_core_out_vld),
      .i_out_rdy  (w_core_out_rdy),
      .o_out_dat  (w_core_dig)
   );

   assign w_xfer     = w_core_in_vld && w_core_in_rdy;
   assign w_dig_take = w_core_out_vld && w_core_out_rdy;
   // Compared before the increment, so c equal to the all-ones count still terminates.
   assign w_last     = (r_cnt == r_iter);

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (v_i)        w_state_nxt = S_IK;
         S_IK:   if (w_xfer)     w_state_nxt = S_W1;
         S_W1:   if (w_dig_take) w_state_nxt = S_IM;
         S_IM:   if (w_xfer)     w_state_nxt = S_W2;
         S_W2:   if (w_dig_take) w_state_nxt = S_OK;
         S_OK:   if (w_xfer)     w_state_nxt = S_W3;
         S_W3:   if (w_dig_take) w_state_nxt = S_OM;
         S_OM:   if (w_xfer)     w_state_nxt = S_W4;
         S_W4:   if (w_dig_take) w_state_nxt = S_ACC;
         S_ACC:                  w_state_nxt = w_last ? S_DONE : S_IK;
         S_DONE: if (r_i)        w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      r_o            = 1'b0;
      v_o            = 1'b0;
      busy_o         = 1'b1;
      w_core_in_vld  = 1'b0;
      w_core_new     = 1'b0;
      w_core_out_rdy = 1'b0;
      w_core_blk     = '0;
      case (r_state)
         S_IDLE: begin
            r_o    = !rst_i;
            busy_o = 1'b0;
         end
         S_IK: begin
            w_core_in_vld = 1'b1;
            w_core_new    = 1'b1;
            w_core_blk    = r_k0 ^ IPAD;
         end
         S_IM: begin
            w_core_in_vld = 1'b1;
            w_core_blk    = (r_cnt == ITER_W'(1)) ? sha_pad(BLOCK_W'(r_msg), MSG_BYTES)
                                                  : sha_pad(BLOCK_W'(r_uprev), DIGEST_W / 8);
         end
         S_OK: begin
            w_core_in_vld = 1'b1;
            w_core_new    = 1'b1;
            w_core_blk    = r_k0 ^ OPAD;
         end
         S_OM: begin
            w_core_in_vld = 1'b1;
            w_core_blk    = sha_pad(BLOCK_W'(r_idig), DIGEST_W / 8);
         end
         S_W1, S_W2, S_W3, S_W4: w_core_out_rdy = 1'b1;
         S_DONE:                 v_o = 1'b1;
         default: ;
      endcase
   end

   // The core keeps the outer digest on its output through ACC, so U_j is read straight from it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_k0    <= '0;
         r_msg   <= '0;
         r_iter  <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_uprev <= '0;
         r_idig  <= '0;
         r_dk    <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (v_i) begin
               r_k0   <= BLOCK_W'(key_i) << (BLOCK_W - KEY_BYTES * 8);
               r_msg  <= msg_i;
               r_iter <= (iter_i == '0) ? ITER_W'(1) : iter_i;
               r_cnt  <= ITER_W'(1);
               r_acc  <= '0;
            end
            S_W2: if (w_dig_take) r_idig <= w_core_dig;
            S_ACC: begin
               r_uprev <= w_core_dig;
               r_acc   <= r_acc ^ w_core_dig;
               if (w_last) r_dk  <= r_acc ^ w_core_dig;
               else        r_cnt <= r_cnt + ITER_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign dk_o = r_dk;

`ifdef PBKDF2_ITER_TRACE_EN
   assign u_o   = w_core_dig;
   assign u_v_o = (r_state == S_ACC);
`endif

endmodule

// File: tb/tb_pbkdf2_hmac_sha256.sv
// Bench for pbkdf2_hmac_sha256 (KEY_BYTES=8, MSG_BYTES=8): byte-level SHA-256/HMAC/PBKDF2 model plus RFC 6070-style literals.
module tb_pbkdf2_hmac_sha256;
   import pbkdf2_pkg::*;

   typedef byte unsigned bq_t[$];

   localparam int KB = 8;
   localparam int MB = 8;
   localparam int IW = 32;

   localparam logic [63:0]  KEY_PW = 64'h70617373776f7264;  // "password"
   localparam logic [63:0]  MSG_S1 = 64'h73616c7400000001;  // "salt" || INT(1)
   localparam logic [255:0] V1 = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
   localparam logic [255:0] V2 = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
   localparam logic [255:0] V3 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

   localparam logic [31:0] MK [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam logic [255:0] MIV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   logic           clk = 1'b0;
   logic           rst_i = 1'b1;
   logic [KB*8-1:0] key_i = '0;
   logic [MB*8-1:0] msg_i = '0;
   logic [IW-1:0]  iter_i = '0;
   logic           v_i = 1'b0;
   logic           r_o;
   logic [255:0]   dk_o;
   logic           v_o;
   logic           r_i = 1'b1;
   logic           busy_o;
`ifdef PBKDF2_ITER_TRACE_EN
   logic [255:0]   u_o;
   logic           u_v_o;
   int             u_cnt = 0;
`endif

   int             n_chk = 0;
   int             n_err = 0;
   int             xfer_cnt = 0;
   bit             chk_en = 1'b0;
   logic [255:0]   exp_dk = '0;

   always #5 clk = ~clk;

   pbkdf2_hmac_sha256 #(.KEY_BYTES(KB), .MSG_BYTES(MB), .ITER_W(IW)) dut (
      .clk_i  (clk),
      .rst_i  (rst_i),
      .key_i  (key_i),
      .msg_i  (msg_i),
      .iter_i (iter_i),
      .v_i    (v_i),
      .r_o    (r_o),
      .dk_o   (dk_o),
      .v_o    (v_o),
      .r_i    (r_i),
      .busy_o (busy_o)
`ifdef PBKDF2_ITER_TRACE_EN
      ,
      .u_o    (u_o),
      .u_v_o  (u_v_o)
`endif
   );

   // ---------------- reference model ----------------
   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] m_block(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] s [8];
      logic [31:0] t1, t2;
      logic [255:0] res;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) s[i] = hin[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + MK[t] + w[t];
         t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
         for (int i = 7; i > 0; i--) s[i] = s[i-1];
         s[4] = s[4] + t1;
         s[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + s[i];
      return res;
   endfunction

   function automatic logic [255:0] m_sha(input bq_t msg);
      bq_t q;
      logic [255:0] h;
      logic [511:0] blk;
      longint unsigned bits;
      q = msg;
      bits = 64'(q.size()) * 8;
      q.push_back(8'h80);
      while ((q.size() % 64) != 56) q.push_back(8'h00);
      for (int i = 7; i >= 0; i--) q.push_back(8'(bits >> (8 * i)));
      h = MIV;
      for (int b = 0; b < q.size() / 64; b++) begin
         for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = q[64*b+j];
         h = m_block(h, blk);
      end
      return h;
   endfunction

   function automatic logic [255:0] m_hmac(input logic [63:0] key, input bq_t msg);
      bq_t qi, qo;
      byte unsigned k0 [64];
      logic [255:0] ih;
      for (int j = 0; j < 64; j++) begin
         k0[j] = 8'h00;
         if (j < KB) k0[j] = key[63-8*j -: 8];
      end
      for (int j = 0; j < 64; j++) qi.push_back(k0[j] ^ 8'h36);
      foreach (msg[j]) qi.push_back(msg[j]);
      ih = m_sha(qi);
      for (int j = 0; j < 64; j++) qo.push_back(k0[j] ^ 8'h5c);
      for (int j = 0; j < 32; j++) qo.push_back(ih[255-8*j -: 8]);
      return m_sha(qo);
   endfunction

   function automatic logic [255:0] m_pbkdf2(input logic [63:0] key, input logic [63:0] msg, input int unsigned c);
      bq_t m;
      logic [255:0] u, t;
      int unsigned n;
      n = (c == 0) ? 1 : c;
      for (int j = 0; j < MB; j++) m.push_back(msg[63-8*j -: 8]);
      u = m_hmac(key, m);
      t = u;
      for (int unsigned j = 2; j <= n; j++) begin
         m.delete();
         for (int k = 0; k < 32; k++) m.push_back(u[255-8*k -: 8]);
         u = m_hmac(key, m);
         t = t ^ u;
      end
      return t;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, 256'(act), 256'(exp));
   endtask

   always @(negedge clk) begin
      if (chk_en && !rst_i) begin
         chk1("ready_is_not_busy", r_o, ~busy_o);
         if (v_o) chk("dk_vs_model", dk_o, exp_dk);
         if (v_o && r_i) xfer_cnt++;
`ifdef PBKDF2_ITER_TRACE_EN
         if (u_v_o) u_cnt++;
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [63:0] k, input logic [63:0] m, input logic [31:0] c);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (r_o !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk1("req_ready", r_o, 1'b1);
      exp_dk = m_pbkdf2(k, m, c);
`ifdef PBKDF2_ITER_TRACE_EN
      u_cnt = 0;
`endif
      key_i = k; msg_i = m; iter_i = c; v_i = 1'b1;
      @(posedge clk); #1;
      v_i = 1'b0;
   endtask

   // Returns at a falling edge with v_o observed high (or the budget spent).
   task automatic wait_done(input string name, input int c, output int ro_hi);
      int n;
      int budget;
      budget = 400 * ((c == 0) ? 1 : c) + 100;
      n = 0;
      ro_hi = 0;
      @(negedge clk);
      while (v_o !== 1'b1 && n < budget) begin
         if (r_o) ro_hi++;
         @(negedge clk);
         n++;
      end
      chk1({name, "_done"}, v_o, 1'b1);
   endtask

   task automatic run_req(input string name, input logic [63:0] k, input logic [63:0] m, input logic [31:0] c,
                          input bit has_lit, input logic [255:0] lit);
      int ro_hi;
      int xs;
      xs = xfer_cnt;
      send(k, m, c);
      wait_done(name, c, ro_hi);
      chk({name, "_r_o_low_while_busy"}, 256'(ro_hi), 256'(0));
      if (has_lit) chk({name, "_dk_literal"}, dk_o, lit);
`ifdef PBKDF2_ITER_TRACE_EN
      chk({name, "_trace_pulses"}, 256'(u_cnt), 256'((c == 0) ? 1 : c));
`endif
      @(negedge clk);
      chk1({name, "_ready_after"}, r_o, 1'b1);
      chk1({name, "_v_o_dropped"}, v_o, 1'b0);
      chk({name, "_one_transfer"}, 256'(xfer_cnt - xs), 256'(1));
      chk({name, "_dk_retained"}, dk_o, exp_dk);
   endtask

   initial begin
      int ro_hi;
      int n;
      int xs;
      bit found;

      chk("model_c1", m_pbkdf2(KEY_PW, MSG_S1, 1), V1);
      chk("model_c2", m_pbkdf2(KEY_PW, MSG_S1, 2), V2);
      chk("model_c4096", m_pbkdf2(KEY_PW, MSG_S1, 4096), V3);

      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_r_o", r_o, 1'b0);
      chk1("rst_v_o", v_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      chk("rst_dk", dk_o, '0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk1("idle_r_o", r_o, 1'b1);
      chk_en = 1'b1;

      run_req("v1", KEY_PW, MSG_S1, 1, 1'b1, V1);
      run_req("v2", KEY_PW, MSG_S1, 2, 1'b1, V2);
      run_req("zero_iter", KEY_PW, MSG_S1, 0, 1'b1, V1);
      run_req("other_key", 64'h4a6566652d6b6579, 64'h0011223344556677, 3, 1'b0, '0);

      // Downstream stall in DONE with stray requests on the input.
      @(posedge clk); #1;
      r_i = 1'b0;
      xs = xfer_cnt;
      send(KEY_PW, MSG_S1, 1);
      wait_done("bp", 1, ro_hi);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         v_i = i[0];
         key_i = ~key_i;
         iter_i = 7;
         @(negedge clk);
         chk1("bp_v_o_held", v_o, 1'b1);
         chk("bp_dk_held", dk_o, V1);
         chk1("bp_r_o_low", r_o, 1'b0);
      end
      @(posedge clk); #1;
      v_i = 1'b0;
      r_i = 1'b1;
      @(negedge clk);
      chk1("bp_release_still_done", r_o, 1'b0);
      @(negedge clk);
      chk1("bp_ready_next", r_o, 1'b1);
      chk1("bp_v_o_dropped", v_o, 1'b0);
      chk("bp_one_transfer", 256'(xfer_cnt - xs), 256'(1));

      // Abort in W2 of iteration 3.
      send(KEY_PW, MSG_S1, 5);
      n = 0;
      found = 1'b0;
      while (!found && n < 2000) begin
         @(negedge clk);
         found = (dut.r_state == S_W2) && (dut.r_cnt == 3);
         n++;
      end
      chk1("reach_w2_iter3", found, 1'b1);
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk1("abort_busy", busy_o, 1'b0);
      chk1("abort_v_o", v_o, 1'b0);
      chk("abort_dk", dk_o, '0);
      chk1("abort_r_o", r_o, 1'b1);

      run_req("v1_after_abort", KEY_PW, MSG_S1, 1, 1'b1, V1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
      $fatal(1);
   end

endmodule
